// File: rtl/mult_checker.sv
// Protocol checker for a start/ready/done multiplier: tracks one operation at a time,
// verifies the product, and reports protocol errors, timeouts, counters and coverage.
module mult_checker #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4*WIDTH+8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic               ready_i,
  input  logic               done_i,
  input  logic [2*WIDTH-1:0] product_i,
  output logic               busy_o,
  output logic               bad_product_o,
  output logic               not_ready_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   txn_cnt_o,
  output logic [CNT_W-1:0]   bp_cnt_o,
  output logic [CNT_W-1:0]   nr_cnt_o,
  output logic [CNT_W-1:0]   to_cnt_o,
  output logic [5:0]         cov_o
);

  // Timer counts 0..TIMEOUT-1; reaching the last value without done is a timeout.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [2*WIDTH-1:0] expected_reg, expected_next;
  logic               ev_bp, ev_nr, ev_to, ev_txn;
  logic [5:0]         cov_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    expected_next = expected_reg;
    ev_bp         = 1'b0;
    ev_nr         = 1'b0;
    ev_to         = 1'b0;
    ev_txn        = 1'b0;
    cov_hit       = 6'b0;
    case (state_reg)
      IDLE: begin
        if (done_i) ev_bp = 1'b1;
        if (start_i) begin
          if (ready_i) begin
            expected_next = (2*WIDTH)'(multiplicand_i) * (2*WIDTH)'(multiplier_i);
            timer_next    = '0;
            state_next    = BUSY;
            cov_hit[0]    = (multiplicand_i == '0);
            cov_hit[1]    = (multiplier_i == '0);
            cov_hit[2]    = &multiplicand_i;
            cov_hit[3]    = &multiplier_i;
            cov_hit[4]    = (&multiplicand_i) & (&multiplier_i);
          end else begin
            ev_nr = 1'b1;
          end
        end
      end
      BUSY: begin
        // A start while busy is only recorded as coverage, even alongside done.
        if (start_i) cov_hit[5] = 1'b1;
        if (done_i) begin
          ev_txn     = 1'b1;
          ev_bp      = (product_i != expected_reg);
          ev_nr      = !ready_i;
          timer_next = '0;
          state_next = IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          ev_to      = 1'b1;
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      expected_reg  <= '0;
      bad_product_o <= 1'b0;
      not_ready_o   <= 1'b0;
      timeout_o     <= 1'b0;
      txn_cnt_o     <= '0;
      bp_cnt_o      <= '0;
      nr_cnt_o      <= '0;
      to_cnt_o      <= '0;
      cov_o         <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      expected_reg  <= expected_next;
      bad_product_o <= ev_bp;
      not_ready_o   <= ev_nr;
      timeout_o     <= ev_to;
      txn_cnt_o     <= sat_inc(txn_cnt_o, ev_txn);
      bp_cnt_o      <= sat_inc(bp_cnt_o, ev_bp);
      nr_cnt_o      <= sat_inc(nr_cnt_o, ev_nr);
      to_cnt_o      <= sat_inc(to_cnt_o, ev_to);
      cov_o         <= cov_o | cov_hit;
    end
  end

  assign busy_o = (state_reg == BUSY);

endmodule

// File: tb/tb_mult_checker.sv
// Self-checking bench for mult_checker: directed scenarios plus randomized
// transactions predicted by a counter/coverage model kept in the bench.
`timescale 1ns/1ps
module tb_mult_checker;
  localparam int W  = 8;
  localparam int TO = 4*W+8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  mcand = '0;
  logic [W-1:0]  mplier = '0;
  logic          ready = 1'b1;
  logic          done = 1'b0;
  logic [2*W-1:0] product = '0;

  logic          busy, bad_product, not_ready, timeout;
  logic [15:0]   txn_cnt, bp_cnt, nr_cnt, to_cnt;
  logic [5:0]    cov;
  logic          s_busy, s_bp, s_nr, s_to;
  logic [1:0]    s_txn, s_bpc, s_nrc, s_toc;
  logic [5:0]    s_cov;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int       m_txn, m_bp, m_nr, m_to;
  logic [5:0] m_cov;

  mult_checker #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .multiplicand_i(mcand),
    .multiplier_i(mplier), .ready_i(ready), .done_i(done), .product_i(product),
    .busy_o(busy), .bad_product_o(bad_product), .not_ready_o(not_ready),
    .timeout_o(timeout), .txn_cnt_o(txn_cnt), .bp_cnt_o(bp_cnt), .nr_cnt_o(nr_cnt),
    .to_cnt_o(to_cnt), .cov_o(cov)
  );

  mult_checker #(.WIDTH(W), .CNT_W(2)) dut_small (
    .clk_i(clk), .reset_i(reset), .start_i(start), .multiplicand_i(mcand),
    .multiplier_i(mplier), .ready_i(ready), .done_i(done), .product_i(product),
    .busy_o(s_busy), .bad_product_o(s_bp), .not_ready_o(s_nr),
    .timeout_o(s_to), .txn_cnt_o(s_txn), .bp_cnt_o(s_bpc), .nr_cnt_o(s_nrc),
    .to_cnt_o(s_toc), .cov_o(s_cov)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] cov_of(input int a, input int b);
    logic [5:0] c;
    c[0] = (a == 0);
    c[1] = (b == 0);
    c[2] = (a == 255);
    c[3] = (b == 255);
    c[4] = (a == 255) && (b == 255);
    c[5] = 1'b0;
    return c;
  endfunction

  task automatic do_reset();
    start = 0; done = 0; ready = 1;
    reset = 1;
    #12;
    reset = 0;
    tick();
    m_txn = 0; m_bp = 0; m_nr = 0; m_to = 0; m_cov = '0;
  endtask

  // Drives one accepted operation whose done arrives lat edges after the start edge.
  task automatic run_op(input int a, input int b, input int lat, input logic [15:0] prod,
                        input logic rdy_done, output logic obp, output logic onr,
                        output logic oto, output logic obusy_mid, output logic obusy_end);
    start = 1; ready = 1; mcand = W'(a); mplier = W'(b);
    tick();
    start = 0;
    obusy_mid = busy;
    for (int i = 1; i < lat; i++) tick();
    done = 1; product = prod; ready = rdy_done;
    tick();
    obp = bad_product; onr = not_ready; oto = timeout; obusy_end = busy;
    done = 0; ready = 1;
    m_cov |= cov_of(a, b);
  endtask

  task automatic test_counters(input string tag);
    tests++; if (txn_cnt !== 16'(m_txn)) begin fails++; $display("FAIL %s txn_cnt got %0d want %0d", tag, txn_cnt, m_txn); end
    tests++; if (bp_cnt !== 16'(m_bp)) begin fails++; $display("FAIL %s bp_cnt got %0d want %0d", tag, bp_cnt, m_bp); end
    tests++; if (nr_cnt !== 16'(m_nr)) begin fails++; $display("FAIL %s nr_cnt got %0d want %0d", tag, nr_cnt, m_nr); end
    tests++; if (to_cnt !== 16'(m_to)) begin fails++; $display("FAIL %s to_cnt got %0d want %0d", tag, to_cnt, m_to); end
    tests++; if (cov !== m_cov) begin fails++; $display("FAIL %s cov got %b want %b", tag, cov, m_cov); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({busy, bad_product, not_ready, timeout} !== 4'b0) begin fails++; $display("FAIL reset flags got %b want 0000", {busy, bad_product, not_ready, timeout}); end
    test_counters("reset");
    $display("[TB] reset: busy=%0d cov=%b", busy, cov);
  endtask

  task automatic test_basic();
    logic bp, nr, to, bm, be;
    run_op(13, 11, 9, 16'd143, 1'b1, bp, nr, to, bm, be);
    m_txn++;
    tests++; if ({bp, nr, to} !== 3'b000) begin fails++; $display("FAIL basic pulses got %b want 000", {bp, nr, to}); end
    tests++; if ({bm, be} !== 2'b10) begin fails++; $display("FAIL basic busy got mid=%0d end=%0d want 1/0", bm, be); end
    test_counters("basic");
    $display("[TB] basic 13*11=143 txn=%0d", txn_cnt);
  endtask

  task automatic test_max();
    logic bp, nr, to, bm, be;
    do_reset();
    run_op(255, 255, 5, 16'hFE01, 1'b1, bp, nr, to, bm, be);
    m_txn++;
    tests++; if ({bp, nr, to} !== 3'b000) begin fails++; $display("FAIL max_ok pulses got %b want 000", {bp, nr, to}); end
    tests++; if (cov !== 6'b011100) begin fails++; $display("FAIL max_cov got %b want 011100", cov); end
    run_op(255, 255, 5, 16'hFE00, 1'b1, bp, nr, to, bm, be);
    m_txn++; m_bp++;
    tests++; if ({bp, nr, to} !== 3'b100) begin fails++; $display("FAIL max_bad pulses got %b want 100", {bp, nr, to}); end
    tick();
    tests++; if (bad_product !== 1'b0) begin fails++; $display("FAIL max_bad_width got %b want 0", bad_product); end
    test_counters("max");
    $display("[TB] max 255*255 bp_cnt=%0d cov=%b", bp_cnt, cov);
  endtask

  task automatic test_not_ready();
    start = 1; ready = 0; mcand = 8'd5; mplier = 8'd6;
    tick();
    start = 0; ready = 1;
    m_nr++;
    tests++; if ({not_ready, busy} !== 2'b10) begin fails++; $display("FAIL not_ready got nr=%0d busy=%0d want 1/0", not_ready, busy); end
    tick();
    tests++; if ({not_ready, busy} !== 2'b00) begin fails++; $display("FAIL not_ready_clear got nr=%0d busy=%0d want 0/0", not_ready, busy); end
    test_counters("not_ready");
    $display("[TB] not_ready nr_cnt=%0d", nr_cnt);
  endtask

  task automatic test_back_to_back();
    logic any_err;
    start = 1; ready = 1; mcand = 8'd9; mplier = 8'd9;
    tick();
    m_cov |= cov_of(9, 9);
    mcand = 8'd200; mplier = 8'd2;
    any_err = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_err |= bad_product | not_ready | timeout;
    end
    // done coincident with start: old operands still expected, start not accepted
    done = 1; product = 16'd81;
    tick();
    start = 0; done = 0;
    m_txn++; m_cov[5] = 1'b1;
    any_err |= bad_product | not_ready | timeout;
    tests++; if (any_err !== 1'b0) begin fails++; $display("FAIL start_in_busy errors got %b want 0", any_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_busy busy got %b want 0", busy); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_busy accepted got busy=%b want 0", busy); end
    test_counters("start_in_busy");
    $display("[TB] start_in_busy cov=%b", cov);
  endtask

  task automatic test_timeout();
    logic early;
    start = 1; ready = 1; mcand = 8'd3; mplier = 8'd4;
    tick();
    start = 0;
    m_cov |= cov_of(3, 4);
    early = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      early |= timeout;
    end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL timeout_early got %b want 0", early); end
    tick();
    m_to++;
    tests++; if ({timeout, bad_product, busy} !== 3'b100) begin fails++; $display("FAIL timeout got to=%0d bp=%0d busy=%0d want 1/0/0", timeout, bad_product, busy); end
    tick();
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_width got %b want 0", timeout); end
    done = 1; product = 16'd12;
    tick();
    done = 0;
    m_bp++;
    tests++; if (bad_product !== 1'b1) begin fails++; $display("FAIL late_done got %b want 1", bad_product); end
    test_counters("timeout");
    $display("[TB] timeout to_cnt=%0d bp_cnt=%0d", to_cnt, bp_cnt);
  endtask

  task automatic test_reset_mid_busy();
    logic bp, nr, to, bm, be;
    start = 1; ready = 1; mcand = 8'd77; mplier = 8'd0;
    tick();
    start = 0;
    tick();
    #3 reset = 1;
    #1;
    tests++; if ({busy, bad_product, not_ready, timeout, txn_cnt, bp_cnt, nr_cnt, to_cnt, cov} !== '0) begin
      fails++; $display("FAIL async_reset got busy=%0d txn=%0d bp=%0d nr=%0d to=%0d cov=%b want all 0", busy, txn_cnt, bp_cnt, nr_cnt, to_cnt, cov);
    end
    #1 reset = 0;
    m_txn = 0; m_bp = 0; m_nr = 0; m_to = 0; m_cov = '0;
    tick();
    run_op(0, 7, 4, 16'd0, 1'b1, bp, nr, to, bm, be);
    m_txn++;
    tests++; if ({bp, nr, to, bm, be} !== 5'b00010) begin fails++; $display("FAIL after_reset got %b want 00010", {bp, nr, to, bm, be}); end
    tests++; if (cov !== 6'b000001) begin fails++; $display("FAIL after_reset_cov got %b want 000001", cov); end
    test_counters("after_reset");
    $display("[TB] reset mid-busy then 0*7 txn=%0d cov=%b", txn_cnt, cov);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      done = 1; product = 16'hFFFF;
      tick();
      done = 0;
      tick();
      m_bp++;
    end
    tests++; if (s_bpc !== 2'd3) begin fails++; $display("FAIL sat_bp_cnt got %0d want 3", s_bpc); end
    tests++; if (s_bp !== 1'b0 || s_txn !== 2'd0) begin fails++; $display("FAIL sat_other got bp=%0d txn=%0d want 0/0", s_bp, s_txn); end
    test_counters("sat_wide");
    $display("[TB] saturation small bp_cnt=%0d wide bp_cnt=%0d", s_bpc, bp_cnt);
  endtask

  task automatic test_random();
    logic bp, nr, to, bm, be;
    logic exp_bp, exp_nr;
    int a, b, kind, lat;
    logic [15:0] prod;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      a = (($urandom_range(0, 7) == 0) ? 255 : (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255)));
      b = (($urandom_range(0, 7) == 0) ? 255 : (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255)));
      lat = $urandom_range(1, TO);
      if (kind <= 2) begin
        prod = 16'(a * b);
        if (kind == 1) prod = prod ^ (16'd1 << $urandom_range(0, 15));
        run_op(a, b, lat, prod, (kind != 2), bp, nr, to, bm, be);
        exp_bp = (kind == 1);
        exp_nr = (kind == 2);
        m_txn++;
        if (exp_bp) m_bp++;
        if (exp_nr) m_nr++;
        tests++; if ({bp, nr, to, bm, be} !== {exp_bp, exp_nr, 1'b0, 1'b1, 1'b0}) begin
          fails++; $display("FAIL rand_op[%0d] %0d*%0d lat=%0d got %b want %b", n, a, b, lat, {bp, nr, to, bm, be}, {exp_bp, exp_nr, 3'b010});
        end
      end else if (kind == 3) begin
        start = 1; ready = 0; mcand = W'(a); mplier = W'(b);
        tick();
        start = 0; ready = 1;
        m_nr++;
        tests++; if ({not_ready, busy} !== 2'b10) begin fails++; $display("FAIL rand_nr[%0d] got nr=%0d busy=%0d want 1/0", n, not_ready, busy); end
      end else begin
        done = 1; product = 16'($urandom_range(0, 65535));
        tick();
        done = 0;
        m_bp++;
        tests++; if ({bad_product, busy} !== 2'b10) begin fails++; $display("FAIL rand_spurious[%0d] got bp=%0d busy=%0d want 1/0", n, bad_product, busy); end
      end
      tick();
      test_counters("rand");
      $display("[TB] rand %0d kind=%0d a=%0d b=%0d lat=%0d txn=%0d bp=%0d nr=%0d", n, kind, a, b, lat, txn_cnt, bp_cnt, nr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_not_ready();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
